// File: rtl/lq_buffer.sv
// Circular load queue: in-order dispatch/completion, oldest-ready issue, CDB wakeup.
// Optional LQ_DISP_BYPASS_EN: capture a matching CDB value while dispatching.
module lq_buffer #(
  parameter  int DEPTH     = 8,
  parameter  int DISP_W    = 2,
  parameter  int NUM_CDB   = 2,
  parameter  int PRF_IDX_W = 6,
  parameter  int ROB_IDX_W = 6,
  localparam int IW        = $clog2(DEPTH),
  localparam int CW        = IW + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [DISP_W-1:0]                   disp_valid,
  input  logic [DISP_W-1:0][63:0]             disp_pc,
  input  logic [DISP_W-1:0][31:0]             disp_inst,
  input  logic [DISP_W-1:0][63:0]             disp_opa,
  input  logic [DISP_W-1:0][63:0]             disp_opb,
  input  logic [DISP_W-1:0]                   disp_opb_valid,
  input  logic [DISP_W-1:0][ROB_IDX_W-1:0]    disp_rob_idx,
  input  logic [DISP_W-1:0][PRF_IDX_W-1:0]    disp_dest_tag,
  output logic [CW-1:0]                       free_count,
  input  logic [NUM_CDB-1:0]                  cdb_valid,
  input  logic [NUM_CDB-1:0][PRF_IDX_W-1:0]   cdb_tag,
  input  logic [NUM_CDB-1:0][63:0]            cdb_data,
  output logic                                mem_req_valid,
  output logic [63:0]                         mem_req_addr,
  output logic [IW-1:0]                       mem_req_id,
  input  logic                                mem_req_ready,
  input  logic                                mem_resp_valid,
  input  logic [IW-1:0]                       mem_resp_id,
  input  logic [63:0]                         mem_resp_data,
  output logic                                cmpl_valid,
  output logic [63:0]                         cmpl_pc,
  output logic [ROB_IDX_W-1:0]                cmpl_rob_idx,
  output logic [PRF_IDX_W-1:0]                cmpl_dest_tag,
  output logic [63:0]                         cmpl_data,
  input  logic                                cmpl_ready
);
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, ADDR_RDY, MEM_PEND, DONE} st_e;
  typedef struct packed {
    logic [63:0]          pc;
    logic [63:0]          opa;
    logic [63:0]          opb;
    logic [63:0]          data;
    logic [ROB_IDX_W-1:0] rob;
    logic [PRF_IDX_W-1:0] dest;
  } ent_t;

  st_e           st   [DEPTH];
  ent_t          ent  [DEPTH];
  logic [IW-1:0] head, tail;
  logic [CW-1:0] drop_cnt;

  logic [DEPTH-1:0]  wake_hit;
  logic [63:0]       wake_data [DEPTH];
  logic [DISP_W-1:0] slot_en, slot_rdy;
  logic [IW-1:0]     slot_idx  [DISP_W];
  logic [63:0]       slot_opb  [DISP_W];
  logic [CW-1:0]     n_alloc, pend_cnt;
  logic              sel_found;
  logic [IW-1:0]     sel_idx, scan_idx;
  logic              accept, cmpl_fire, resp_take;

  assign accept    = mem_req_valid && mem_req_ready;
  assign cmpl_fire = cmpl_valid && cmpl_ready;
  assign resp_take = mem_resp_valid && (drop_cnt == '0);

  assign cmpl_valid    = (st[head] == DONE);
  assign cmpl_pc       = ent[head].pc;
  assign cmpl_rob_idx  = ent[head].rob;
  assign cmpl_dest_tag = ent[head].dest;
  assign cmpl_data     = ent[head].data;

  // Slot allocation is capped by the registered free count; higher slots lose first.
  always_comb begin
    n_alloc = '0;
    for (int s = 0; s < DISP_W; s++) begin
      slot_en[s]  = 1'b0;
      slot_idx[s] = tail + n_alloc[IW-1:0];
      slot_rdy[s] = disp_opb_valid[s];
      slot_opb[s] = disp_opb[s];
`ifdef LQ_DISP_BYPASS_EN
      for (int c = NUM_CDB - 1; c >= 0; c--)
        if (!disp_opb_valid[s] && cdb_valid[c] && cdb_tag[c] == disp_opb[s][PRF_IDX_W-1:0]) begin
          slot_rdy[s] = 1'b1;
          slot_opb[s] = cdb_data[c];
        end
`endif
      if (disp_valid[s] && n_alloc < free_count) begin
        slot_en[s] = 1'b1;
        n_alloc    = n_alloc + CW'(1);
      end
    end
  end

  // Descending scan so the lowest matching CDB port wins.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wake_hit[e]  = 1'b0;
      wake_data[e] = ent[e].opb;
      for (int c = NUM_CDB - 1; c >= 0; c--)
        if (st[e] == WAIT_ADDR && cdb_valid[c] && cdb_tag[c] == ent[e].opb[PRF_IDX_W-1:0]) begin
          wake_hit[e]  = 1'b1;
          wake_data[e] = cdb_data[c];
        end
    end
  end

  // Oldest-ready pick walks from the head; the entry already on the request bus is skipped.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = head;
    scan_idx  = head;
    pend_cnt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + IW'(k);
      if (!sel_found && st[scan_idx] == ADDR_RDY && !(mem_req_valid && scan_idx == mem_req_id)) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
    for (int e = 0; e < DEPTH; e++)
      if (st[e] == MEM_PEND) pend_cnt = pend_cnt + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        st[e]  <= IDLE;
        ent[e] <= '0;
      end
      head          <= '0;
      tail          <= '0;
      free_count    <= CW'(DEPTH);
      drop_cnt      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_id    <= '0;
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) st[e] <= IDLE;
      head          <= '0;
      tail          <= '0;
      free_count    <= CW'(DEPTH);
      drop_cnt      <= pend_cnt + CW'(accept);
      mem_req_valid <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        case (st[e])
          WAIT_ADDR: if (wake_hit[e]) begin
            st[e]     <= ADDR_RDY;
            ent[e].opb <= wake_data[e];
          end
          ADDR_RDY: if (accept && mem_req_id == IW'(e)) st[e] <= MEM_PEND;
          MEM_PEND: if (resp_take && mem_resp_id == IW'(e)) begin
            st[e]      <= DONE;
            ent[e].data <= mem_resp_data;
          end
          DONE: if (cmpl_fire && head == IW'(e)) st[e] <= IDLE;
          default: ;
        endcase
        for (int s = 0; s < DISP_W; s++)
          if (slot_en[s] && slot_idx[s] == IW'(e)) begin
            st[e]  <= slot_rdy[s] ? ADDR_RDY : WAIT_ADDR;
            ent[e] <= '{pc: disp_pc[s], opa: disp_opa[s], opb: slot_opb[s], data: '0,
                        rob: disp_rob_idx[s], dest: disp_dest_tag[s]};
          end
      end
      head       <= head + IW'(cmpl_fire);
      tail       <= tail + n_alloc[IW-1:0];
      free_count <= free_count - n_alloc + CW'(cmpl_fire);
      if (mem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      // Request register reloads only when empty or just accepted, and not while draining.
      if (!mem_req_valid || accept) begin
        mem_req_valid <= sel_found && (drop_cnt == '0);
        if (sel_found) begin
          mem_req_addr <= ent[sel_idx].opa + ent[sel_idx].opb;
          mem_req_id   <= sel_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_lq_buffer.sv
// Directed bench for lq_buffer: single load, wakeup, out-of-order responses,
// full/wrap, flush drain and same-cycle contention.
module tb_lq_buffer;
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush;
  logic [1:0]       disp_valid;
  logic [1:0][63:0] disp_pc;
  logic [1:0][31:0] disp_inst;
  logic [1:0][63:0] disp_opa;
  logic [1:0][63:0] disp_opb;
  logic [1:0]       disp_opb_valid;
  logic [1:0][5:0]  disp_rob_idx;
  logic [1:0][5:0]  disp_dest_tag;
  logic [3:0]       free_count;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag;
  logic [1:0][63:0] cdb_data;
  logic             mem_req_valid;
  logic [63:0]      mem_req_addr;
  logic [2:0]       mem_req_id;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [2:0]       mem_resp_id;
  logic [63:0]      mem_resp_data;
  logic             cmpl_valid;
  logic [63:0]      cmpl_pc;
  logic [5:0]       cmpl_rob_idx;
  logic [5:0]       cmpl_dest_tag;
  logic [63:0]      cmpl_data;
  logic             cmpl_ready;

  int compared   = 0;
  int mismatched = 0;

  lq_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_inst(disp_inst),
    .disp_opa(disp_opa), .disp_opb(disp_opb), .disp_opb_valid(disp_opb_valid),
    .disp_rob_idx(disp_rob_idx), .disp_dest_tag(disp_dest_tag),
    .free_count(free_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_id(mem_resp_id), .mem_resp_data(mem_resp_data),
    .cmpl_valid(cmpl_valid), .cmpl_pc(cmpl_pc), .cmpl_rob_idx(cmpl_rob_idx),
    .cmpl_dest_tag(cmpl_dest_tag), .cmpl_data(cmpl_data), .cmpl_ready(cmpl_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    flush = 0; disp_valid = '0; disp_pc = '0; disp_inst = '0; disp_opa = '0;
    disp_opb = '0; disp_opb_valid = '0; disp_rob_idx = '0; disp_dest_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_id = '0; mem_resp_data = '0; cmpl_ready = 0;
  endtask

  task automatic load(input int s, input logic [63:0] pc, input logic [63:0] opa,
                      input logic [63:0] opb, input logic ov, input logic [5:0] rob,
                      input logic [5:0] dest);
    disp_valid[s] = 1'b1; disp_pc[s] = pc; disp_inst[s] = 32'h0000_3003;
    disp_opa[s] = opa; disp_opb[s] = opb; disp_opb_valid[s] = ov;
    disp_rob_idx[s] = rob; disp_dest_tag[s] = dest;
  endtask

  task automatic resp(input logic [2:0] id, input logic [63:0] d);
    mem_resp_valid = 1'b1; mem_resp_id = id; mem_resp_data = d;
  endtask

  initial begin
    quiet();
    #12;
    chk("rst_free", free_count, 8);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_cmpl_valid", cmpl_valid, 0);
    chk("rst_cmpl_data", cmpl_data, 0);
    reset = 0;

    // single load
    load(0, 64'h400, 64'h1000, 64'h20, 1, 3, 7);
    tick(); quiet();
    chk("t1_free_after_disp", free_count, 7);
    chk("t1_no_req_yet", mem_req_valid, 0);
    tick();
    chk("t1_req_valid", mem_req_valid, 1);
    chk("t1_req_addr", mem_req_addr, 64'h1020);
    chk("t1_req_id", mem_req_id, 0);
    tick();
    chk("t1_req_hold_valid", mem_req_valid, 1);
    chk("t1_req_hold_addr", mem_req_addr, 64'h1020);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    chk("t1_req_after_accept", mem_req_valid, 0);
    resp(0, 64'hDEAD); tick(); quiet();
    chk("t1_cmpl_valid", cmpl_valid, 1);
    chk("t1_cmpl_data", cmpl_data, 64'hDEAD);
    chk("t1_cmpl_pc", cmpl_pc, 64'h400);
    chk("t1_cmpl_rob", cmpl_rob_idx, 3);
    chk("t1_cmpl_dest", cmpl_dest_tag, 7);
    cmpl_ready = 1; tick(); cmpl_ready = 0;
    chk("t1_cmpl_gone", cmpl_valid, 0);
    chk("t1_free_back", free_count, 8);

    // tag wakeup on cdb1, cdb0 carries the same tag but is not valid
    load(0, 64'h500, 64'h2000, 64'd5, 0, 4, 8);
    tick(); quiet();
    tick();
    chk("t2_wait_no_req", mem_req_valid, 0);
    cdb_valid = 2'b10; cdb_tag[1] = 6'd5; cdb_data[1] = 64'h8;
    cdb_tag[0] = 6'd5; cdb_data[0] = 64'h99;
    tick(); quiet();
    chk("t2_wake_cycle_no_req", mem_req_valid, 0);
    tick();
    chk("t2_req_valid", mem_req_valid, 1);
    chk("t2_req_addr", mem_req_addr, 64'h2008);
    chk("t2_req_id", mem_req_id, 1);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    resp(1, 64'h55); tick(); quiet();
    chk("t2_cmpl_data", cmpl_data, 64'h55);
    cmpl_ready = 1; tick(); cmpl_ready = 0;
    chk("t2_free_back", free_count, 8);

    // out-of-order responses; B also checks lowest CDB port wins
    load(0, 64'h600, 64'h3000, 64'h4, 1, 10, 12);
    load(1, 64'h604, 64'h5000, 64'd9, 0, 11, 13);
    tick(); quiet();
    cdb_valid = 2'b11; cdb_tag[0] = 6'd9; cdb_data[0] = 64'h10;
    cdb_tag[1] = 6'd9; cdb_data[1] = 64'h30;
    tick(); quiet();
    chk("t3_free", free_count, 6);
    chk("t3_reqA_id", mem_req_id, 2);
    chk("t3_reqA_addr", mem_req_addr, 64'h3004);
    mem_req_ready = 1; tick();
    chk("t3_reqB_valid", mem_req_valid, 1);
    chk("t3_reqB_id", mem_req_id, 3);
    chk("t3_reqB_addr", mem_req_addr, 64'h5010);
    tick(); mem_req_ready = 0;
    chk("t3_req_idle", mem_req_valid, 0);
    resp(3, 64'hBB); tick(); quiet();
    chk("t3_B_done_waits", cmpl_valid, 0);
    cmpl_ready = 1; resp(2, 64'hAA); tick();
    mem_resp_valid = 0;
    chk("t3_A_cmpl_valid", cmpl_valid, 1);
    chk("t3_A_cmpl_data", cmpl_data, 64'hAA);
    chk("t3_A_cmpl_rob", cmpl_rob_idx, 10);
    tick();
    chk("t3_B_cmpl_valid", cmpl_valid, 1);
    chk("t3_B_cmpl_data", cmpl_data, 64'hBB);
    chk("t3_B_cmpl_rob", cmpl_rob_idx, 11);
    tick(); cmpl_ready = 0;
    chk("t3_empty", cmpl_valid, 0);
    chk("t3_free_back", free_count, 8);

    // flush of an empty queue rewinds head/tail to 0 with nothing to drain
    flush = 1; tick(); quiet();

    // full and wrap
    load(0, 64'h700, 64'h4000, 64'h0, 1, 30, 1);
    load(1, 64'h704, 64'h4100, 64'h4, 1, 31, 2);
    tick(); quiet();
    for (int i = 0; i < 3; i++) begin
      load(0, 64'h710, 64'h0, 64'd60, 0, 6'(32 + 2 * i), 3);
      load(1, 64'h714, 64'h0, 64'd60, 0, 6'(33 + 2 * i), 4);
      tick(); quiet();
    end
    chk("t4_full", free_count, 0);
    chk("t4_req_id0", mem_req_id, 0);
    chk("t4_req_addr0", mem_req_addr, 64'h4000);
    load(0, 64'h7F0, 64'hBAD000, 64'h0, 1, 40, 5);
    load(1, 64'h7F4, 64'hBAD100, 64'h0, 1, 41, 6);
    tick(); quiet();
    chk("t4_overflow_dropped", free_count, 0);
    mem_req_ready = 1; tick();
    chk("t4_req_id1", mem_req_id, 1);
    chk("t4_req_addr1", mem_req_addr, 64'h4104);
    tick(); mem_req_ready = 0;
    chk("t4_req_idle", mem_req_valid, 0);
    resp(0, 64'h40); tick();
    resp(1, 64'h41); tick(); quiet();
    chk("t4_cmpl0_data", cmpl_data, 64'h40);
    chk("t4_cmpl0_rob", cmpl_rob_idx, 30);
    cmpl_ready = 1; tick();
    chk("t4_cmpl1_data", cmpl_data, 64'h41);
    chk("t4_free1", free_count, 1);
    tick(); cmpl_ready = 0;
    chk("t4_head_waits", cmpl_valid, 0);
    chk("t4_free2", free_count, 2);
    load(0, 64'h800, 64'h7000, 64'h8, 1, 42, 7);
    load(1, 64'h804, 64'h7100, 64'h8, 1, 43, 8);
    tick(); quiet();
    chk("t4_full_again", free_count, 0);
    tick();
    chk("t4_wrap_req_id0", mem_req_id, 0);
    chk("t4_wrap_req_addr0", mem_req_addr, 64'h7008);
    mem_req_ready = 1; tick();
    chk("t4_wrap_req_id1", mem_req_id, 1);
    chk("t4_wrap_req_addr1", mem_req_addr, 64'h7108);
    tick(); mem_req_ready = 0;
    chk("t4_wrap_req_idle", mem_req_valid, 0);

    // flush with entries 0 and 1 in MEM_PEND
    flush = 1; tick(); quiet();
    chk("t5_free", free_count, 8);
    chk("t5_cmpl", cmpl_valid, 0);
    chk("t5_req", mem_req_valid, 0);
    load(0, 64'h900, 64'h8000, 64'h4, 1, 20, 21);
    tick(); quiet();
    tick();
    chk("t5_drain2_no_req", mem_req_valid, 0);
    resp(0, 64'hE0); tick(); quiet();
    chk("t5_drain1_no_req", mem_req_valid, 0);
    chk("t5_late_resp_no_cmpl", cmpl_valid, 0);
    resp(1, 64'hE1); tick(); quiet();
    chk("t5_drain0_no_req", mem_req_valid, 0);
    tick();
    chk("t5_req_valid", mem_req_valid, 1);
    chk("t5_req_addr", mem_req_addr, 64'h8004);
    chk("t5_req_id", mem_req_id, 0);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    chk("t5_req_idle", mem_req_valid, 0);

    // contention: 2 dispatches + accept + completion in one cycle
    resp(0, 64'h80);
    load(0, 64'hA00, 64'h9000, 64'h10, 1, 22, 23);
    tick(); quiet();
    tick();
    chk("t6_cmpl_valid", cmpl_valid, 1);
    chk("t6_cmpl_data", cmpl_data, 64'h80);
    chk("t6_req_id", mem_req_id, 1);
    chk("t6_req_addr", mem_req_addr, 64'h9010);
    chk("t6_free_before", free_count, 6);
    load(0, 64'hB00, 64'hA000, 64'h0, 1, 24, 25);
    load(1, 64'hB04, 64'hB000, 64'h0, 1, 26, 27);
    mem_req_ready = 1; cmpl_ready = 1;
    tick(); quiet();
    chk("t6_free_after", free_count, 5);
    chk("t6_head_pend", cmpl_valid, 0);
    chk("t6_req_gap", mem_req_valid, 0);
    tick();
    chk("t6_next_req_valid", mem_req_valid, 1);
    chk("t6_next_req_id", mem_req_id, 2);
    chk("t6_next_req_addr", mem_req_addr, 64'hA000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/lq_buffer.md
Name: lq_buffer

Overview:
Parametrised circular load queue that replaces per-entry load slots with one DEPTH-entry buffer. Accepts up to DISP_W loads per cycle in program order and wakes unresolved address operands from NUM_CDB result buses. Issues one memory request per cycle, oldest ready first, and completes loads in order from the head. Sits between dispatch/rename and the data-memory interface; completion feeds the CDB arbiter and ROB.

Parameters:
DEPTH, 8, entry count; power of two, at least 4.
DISP_W, 2, dispatch slots per cycle; slot 0 is older.
NUM_CDB, 2, CDB broadcast ports.
PRF_IDX_W, 6, physical register tag width.
ROB_IDX_W, 6, ROB index width.

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high
flush  in  1  squash all entries
disp_valid  in  DISP_W  slot valid
disp_pc  in  DISP_W*64  load PC
disp_inst  in  DISP_W*32  instruction word
disp_opa  in  DISP_W*64  base value, always ready
disp_opb  in  DISP_W*64  offset value, or PRF tag in [PRF_IDX_W-1:0]
disp_opb_valid  in  DISP_W  1 = opb is a value
disp_rob_idx  in  DISP_W*ROB_IDX_W  ROB index
disp_dest_tag  in  DISP_W*PRF_IDX_W  destination PRF tag
free_count  out  $clog2(DEPTH)+1  free entries at start of cycle
cdb_valid  in  NUM_CDB  broadcast valid
cdb_tag  in  NUM_CDB*PRF_IDX_W  broadcast tag
cdb_data  in  NUM_CDB*64  broadcast value
mem_req_valid  out  1  request valid
mem_req_addr  out  64  load address
mem_req_id  out  $clog2(DEPTH)  entry index
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  response valid
mem_resp_id  in  $clog2(DEPTH)  entry index of response
mem_resp_data  in  64  loaded data
cmpl_valid  out  1  head load complete
cmpl_pc  out  64  head PC
cmpl_rob_idx  out  ROB_IDX_W  head ROB index
cmpl_dest_tag  out  PRF_IDX_W  head destination tag
cmpl_data  out  64  head loaded value
cmpl_ready  in  1  consumer takes completion

Behaviour:
- Reset (async): all entries IDLE; head=tail=0; drop_cnt=0. Outputs: free_count=DEPTH, mem_req_valid=0, cmpl_valid=0, and every data output 0.
- Entry states: IDLE, WAIT_ADDR, ADDR_RDY, MEM_PEND, DONE.
- Dispatch:
  - Valid slots allocate at tail in slot order; tail advances by the number allocated, modulo DEPTH.
  - opb_valid=1 -> ADDR_RDY; opb_valid=0 -> WAIT_ADDR.
  - Upstream must not exceed free_count. Slots beyond free entries are dropped, and higher slots are dropped first.
- Wakeup:
  - A WAIT_ADDR entry whose opb tag equals a valid cdb_tag captures cdb_data into opb and goes to ADDR_RDY next cycle.
  - Every CDB port is compared; on multiple matches the lowest port wins.
- Address: opa+opb, 64-bit with wrap-around and no carry-out.
- Issue:
  - mem_req selects the ADDR_RDY entry nearest the head.
  - mem_req_valid is registered; addr and id hold stable until mem_req_ready.
  - Accept (valid&&ready) moves the entry to MEM_PEND; the next request is presented no earlier than the following cycle.
  - Back-to-back accepts are allowed, one per cycle.
- Response:
  - mem_resp_valid with an id in MEM_PEND latches data and moves the entry to DONE.
  - A response to any other state is ignored.
  - Responses may return out of order.
- Completion:
  - cmpl_* is combinational from the head entry; cmpl_valid = head in DONE.
  - cmpl_valid&&cmpl_ready frees the head and advances it by 1.
  - In-order only: a DONE non-head entry waits.
- free_count = DEPTH minus occupied entries, registered. Entries freed this cycle are reusable only next cycle.
- Flush:
  - All entries go to IDLE; head=tail=0; same-cycle dispatch is discarded.
  - drop_cnt is loaded with the number of MEM_PEND entries, plus 1 if a request is accepted that cycle.
  - While drop_cnt>0: every mem_resp_valid is discarded and decrements drop_cnt, and mem_req_valid is forced 0. Dispatch stays allowed.
  - Flush wins over every other same-cycle event.
- Full: free_count=0; tail==head with the entry occupied.
- Empty: cmpl_valid=0, mem_req_valid=0.

Optional Feature:
LQ_DISP_BYPASS_EN
- Defined: a dispatching slot with opb_valid=0 whose tag matches a valid CDB in the same cycle is written as ADDR_RDY with the CDB value.
- Undefined: no same-cycle capture. The entry enters WAIT_ADDR and wakes only on a later broadcast; rename guarantees such a tag is already resolved.

Test Plan:
- Single load: opa=0x1000, opb=0x20 (valid). Required: mem_req_addr=0x1020, id 0. Resp data 0xDEAD. Then cmpl_valid with cmpl_data=0xDEAD; free_count returns to 8.
- Tag wakeup: slot0 with opb tag 5 (not valid). cdb1 broadcasts tag5=0x8 two cycles later, with cdb0 idle. Required: the request follows, address opa+0x8.
- Out-of-order responses: loads A,B issued; response B arrives before A. Required: cmpl waits for A, then completes A, then B on consecutive cycles with cmpl_ready=1.
- Full and wrap: 8 loads dispatched, then 2 completed. Required: free_count=0, then 2. Two new loads land at indices 0,1 after the tail wrapped.
- Flush with 2 MEM_PEND: 1 cycle later dispatch a new load. Required: the 2 late responses are dropped, there is no mem_req until both arrive, then the new load issues.
- Contention: dispatch 2 slots plus an issue accept plus a completion in one cycle. Required: tail+2, head+1, free_count updated by -1 next cycle.
